// File: rtl/matvec8_requant.sv
// Requantizes the matvec result stream: ReLU, round-half-up shift, saturate to OUT_W,
// tags each element with its vector position and reports the vector argmax on the last beat.
module matvec8_requant #(
  parameter int IN_W    = 28,
  parameter int OUT_W   = 14,
  parameter int VEC_LEN = 8,
  parameter int SHIFT   = 7,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       input_valid,
  output logic                       input_ready,
  input  logic signed [IN_W-1:0]     input_data,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic signed [OUT_W-1:0]    output_data,
  output logic [$clog2(VEC_LEN)-1:0] output_index,
  output logic                       output_last,
  output logic [$clog2(VEC_LEN)-1:0] output_argmax
);
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic signed [IN_W:0] RND    = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_HI = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic [IDX_W-1:0]        idx;
    logic                    last;
    logic [IDX_W-1:0]        amax;
  } entry_t;

  logic                    s1_valid_q, s1_valid_d;
  entry_t                  s1_q, s1_d;
  entry_t                  mem_q [2];
  entry_t                  mem_d [2];
  logic                    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]              count_q, count_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d, amax_q, amax_d;
  logic signed [OUT_W-1:0] max_q, max_d;

  logic signed [IN_W:0]    v_ext, sum, shr;
  logic signed [OUT_W-1:0] qv;
  logic                    in_fire, push, pop, take, last_in;

  assign input_ready   = !s1_valid_q || (count_q < 2'd2);
  assign output_valid  = (count_q != 2'd0);
  assign output_data   = mem_q[rd_ptr_q].data;
  assign output_index  = mem_q[rd_ptr_q].idx;
  assign output_last   = mem_q[rd_ptr_q].last;
  assign output_argmax = mem_q[rd_ptr_q].amax;

  // Extra bit of headroom keeps the rounding add from wrapping at the top of the range.
  always_comb begin
    v_ext = (RELU_EN && input_data[IN_W-1]) ? '0 : {input_data[IN_W-1], input_data};
    sum   = v_ext + RND;
    shr   = sum >>> SHIFT;
    if (shr > SAT_HI)      qv = SAT_HI[OUT_W-1:0];
    else if (shr < SAT_LO) qv = SAT_LO[OUT_W-1:0];
    else                   qv = shr[OUT_W-1:0];
  end

  always_comb begin
    in_fire = input_valid && input_ready && !reset;
    pop     = output_valid && output_ready;
    push    = s1_valid_q && ((count_q < 2'd2) || pop);
    last_in = (cnt_q == IDX_W'(VEC_LEN - 1));
    // Index 0 restarts the tracker; strict compare keeps the lowest index on ties.
    take    = (cnt_q == '0) || (qv > max_q);

    cnt_d  = in_fire ? IDX_W'(cnt_q + 1'b1) : cnt_q;
    max_d  = (in_fire && take) ? qv : max_q;
    amax_d = (in_fire && take) ? cnt_q : amax_q;

    s1_d = s1_q;
    if (in_fire) begin
      s1_d.data = qv;
      s1_d.idx  = cnt_q;
      s1_d.last = last_in;
      s1_d.amax = last_in ? (take ? cnt_q : amax_q) : '0;
    end
    s1_valid_d = in_fire ? 1'b1 : (push ? 1'b0 : s1_valid_q);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s1_q;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      cnt_q      <= '0;
      amax_q     <= '0;
      max_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      amax_q     <= amax_d;
      max_q      <= max_d;
    end
  end
endmodule

// File: tb/tb_matvec8_requant.sv
// Scoreboard bench for matvec8_requant: a ReLU instance under directed and random traffic,
// plus a non-ReLU instance for signed rounding and saturation.
module tb_matvec8_requant;
  localparam int IN_W = 28, OUT_W = 14, VEC_LEN = 8, SHIFT = 7, IDX_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                    input_valid, input_ready, output_valid, output_ready, output_last;
  logic [IN_W-1:0]         input_data;
  logic signed [OUT_W-1:0] output_data;
  logic [IDX_W-1:0]        output_index, output_argmax;

  logic                    nr_ivalid, nr_iready, nr_ovalid, nr_oready, nr_last;
  logic [IN_W-1:0]         nr_idata;
  logic signed [OUT_W-1:0] nr_odata;
  logic [IDX_W-1:0]        nr_index, nr_argmax;

  matvec8_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .VEC_LEN(VEC_LEN), .SHIFT(SHIFT), .RELU_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .output_index(output_index), .output_last(output_last), .output_argmax(output_argmax));

  matvec8_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .VEC_LEN(VEC_LEN), .SHIFT(SHIFT), .RELU_EN(1'b0)) u_dut_nr (
    .clk(clk), .reset(reset),
    .input_valid(nr_ivalid), .input_ready(nr_iready), .input_data(nr_idata),
    .output_valid(nr_ovalid), .output_ready(nr_oready), .output_data(nr_odata),
    .output_index(nr_index), .output_last(nr_last), .output_argmax(nr_argmax));

  typedef struct { longint data; longint idx; longint last; longint amax; } exp_t;
  exp_t exp_q[$];
  exp_t nr_q[$];
  int   m_cnt = 0, nr_cnt = 0;
  int   cur_vec[VEC_LEN];
  int   checks = 0, passed = 0;
  int   cyc = 0;
  int   first_valid_cyc = -1, last_pop_cyc = -1, last_acc_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: floor((v + 2^(SHIFT-1)) / 2^SHIFT), clamped to the OUT_W signed range.
  function automatic longint quant(input longint x, input bit relu);
    longint v, n, den, q;
    v   = (relu && x < 0) ? 0 : x;
    den = longint'(1) << SHIFT;
    n   = v + den / 2;
    q   = n / den;
    if ((n % den) != 0 && n < 0) q = q - 1;
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    return q;
  endfunction

  function automatic longint sext(input logic [IN_W-1:0] d);
    return longint'($signed(d));
  endfunction

  task automatic model_accept(input logic [IN_W-1:0] d);
    exp_t e;
    int best;
    e.data = quant(sext(d), 1'b1);
    cur_vec[m_cnt] = int'(e.data);
    e.idx  = m_cnt;
    e.last = (m_cnt == VEC_LEN - 1);
    e.amax = 0;
    if (m_cnt == VEC_LEN - 1) begin
      best = 0;
      for (int i = 1; i < VEC_LEN; i++) if (cur_vec[i] > cur_vec[best]) best = i;
      e.amax = best;
    end
    exp_q.push_back(e);
    m_cnt = (m_cnt + 1) % VEC_LEN;
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    bit acc = 1'b0;
    input_valid = 1'b1;
    input_data  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (input_ready) begin
        acc = 1'b1;
        model_accept(d);
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    input_valid = 1'b0;
  endtask

  task automatic nr_send(input logic [IN_W-1:0] d);
    bit acc = 1'b0;
    exp_t e;
    nr_ivalid = 1'b1;
    nr_idata  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (nr_iready) begin
        acc    = 1'b1;
        e.data = quant(sext(d), 1'b0);
        e.idx  = nr_cnt;
        e.last = (nr_cnt == VEC_LEN - 1);
        e.amax = 0;
        nr_q.push_back(e);
        nr_cnt = (nr_cnt + 1) % VEC_LEN;
      end
      @(posedge clk); #1;
    end
    if (!acc) check("nr_send_timeout", 0, 1);
    nr_ivalid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      done = (exp_q.size() == 0) && (nr_q.size() == 0) && !output_valid && !nr_ovalid;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  function automatic logic [IN_W-1:0] rand_data();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom_range(0, 4000)) - 2000;
      1:       v = int'($urandom);
      2:       v = int'($urandom_range(0, 2200000)) - 1100000;
      default: v = (int'($urandom_range(0, 200)) - 100) * 128 + 63 + int'($urandom_range(0, 1));
    endcase
    return v[IN_W-1:0];
  endfunction

  // Main-instance monitor: scoreboard pop on every transfer, plus head stability under stall.
  initial begin
    bit stall = 1'b0;
    logic [OUT_W+2*IDX_W:0] held;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) stall = 1'b0;
      else begin
        if (stall) check("hold_stable", {output_data, output_index, output_last, output_argmax}, held);
        if (output_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (output_valid && output_ready) begin
          if (exp_q.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("data", longint'(output_data), e.data);
            check("index", output_index, e.idx);
            check("last", output_last, e.last);
            check("argmax", output_argmax, e.amax);
            last_pop_cyc = cyc;
          end
        end
        stall = output_valid && !output_ready;
        held  = {output_data, output_index, output_last, output_argmax};
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && nr_ovalid && nr_oready) begin
        if (nr_q.size() == 0) check("nr_unexpected_output", 1, 0);
        else begin
          e = nr_q.pop_front();
          check("nr_data", longint'(nr_odata), e.data);
          check("nr_index", nr_index, e.idx);
          check("nr_last", nr_last, e.last);
          check("nr_argmax", nr_argmax, e.amax);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vec_vals[8] = '{5, 300, -20, 300, 100, 0, 200, 299};
    int lat_vals[4] = '{1000, -1000, 63, 64};
    int nr_vals[5]  = '{-1000, -64, -65, 134217727, -134217728};
    int t0, acc_n;
    logic [IN_W-1:0] d;
    bit rdone;

    reset = 1'b1; input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
    nr_ivalid = 1'b0; nr_idata = '0; nr_oready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_output_valid", output_valid, 0);
    check("rst_input_ready", input_ready, 1);
    check("rst_output_data", longint'(output_data), 0);
    check("rst_output_index", output_index, 0);
    check("rst_output_last", output_last, 0);
    check("rst_output_argmax", output_argmax, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vector with a tie between index 1 and 3.
    output_ready = 1'b1;
    foreach (vec_vals[i]) begin d = vec_vals[i][IN_W-1:0]; send(d); end
    wait_drain();

    // Latency and back-to-back throughput from an empty FIFO.
    first_valid_cyc = -1;
    foreach (lat_vals[i]) begin
      d = lat_vals[i][IN_W-1:0];
      send(d);
      if (i == 0) t0 = last_acc_cyc;
    end
    wait_drain();
    check("latency", first_valid_cyc - t0, 2);
    check("throughput", last_pop_cyc - t0, 5);

    foreach (nr_vals[i]) begin d = nr_vals[i][IN_W-1:0]; nr_send(d); end
    wait_drain();

    // Back-pressure: stage 1 plus two FIFO entries fill, then the input stalls.
    output_ready = 1'b0;
    acc_n = 0;
    input_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = IN_W'(1000 * (acc_n + 1));
      input_data = d;
      @(negedge clk);
      if (input_ready) begin model_accept(d); acc_n++; end
      @(posedge clk); #1;
    end
    input_valid = 1'b0;
    check("bp_accepted", acc_n, 3);
    @(negedge clk);
    check("bp_input_ready", input_ready, 0);
    @(posedge clk); #1;
    output_ready = 1'b1;
    wait_drain();

    // Random traffic with toggling output_ready.
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 64 * VEC_LEN; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(rand_data());
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          output_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    output_ready = 1'b1;
    wait_drain();

    // Reset with stage 1 and both FIFO entries occupied mid-vector.
    output_ready = 1'b0;
    repeat (3) send(rand_data());
    @(negedge clk);
    check("pre_rst_output_valid", output_valid, 1);
    check("pre_rst_input_ready", input_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    nr_q.delete();
    m_cnt = 0;
    nr_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_output_valid", output_valid, 0);
    check("mid_rst_input_ready", input_ready, 1);
    @(posedge clk); #1;
    output_ready = 1'b1;
    d = IN_W'(5000);
    send(d);
    wait_drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
